// File: rtl/dmux8_dispatch_pkg.sv
// Shared types and constants for the 8-lane dispatch demultiplexer.
package dmux8_dispatch_pkg;

  localparam int LANES   = 8;
  localparam int SEL_W   = 3;
  localparam int STALL_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic logic [LANES-1:0] lane_onehot(input logic [SEL_W-1:0] sel);
    logic [LANES-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dispatch_fifo2.sv
// Two-entry FIFO holding {sel, data} words between the source and the lane holding register.
module dispatch_fifo2 #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         empty_next_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         do_push;
  logic         do_pop;

  assign do_push = push_i & (count_q != 2'd2);
  assign do_pop  = pop_i & (count_q != 2'd0);

  // Occupancy next-state; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign rdata_o      = mem_q[rd_ptr_q];
  assign empty_o      = (count_q == 2'd0);
  assign full_o       = (count_q == 2'd2);
  assign empty_next_o = (count_d == 2'd0);

endmodule

// File: rtl/dmux8_dispatch.sv
// Routes buffered words to one of 8 lanes with valid/ready handshakes.
// Optional stall timeout/drop enabled by defining DMUX8_DISPATCH_TIMEOUT_EN.
module dmux8_dispatch
  import dmux8_dispatch_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_valid,
  input  logic [LANES-1:0]       out_ready,
  output logic                   busy,
  output logic                   err_timeout
);

  localparam int FW = WIDTH + SEL_W;

  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_timeout_range
    $error("dmux8_dispatch: TIMEOUT must be within 1..255");
  end

  logic [FW-1:0]          fifo_rdata;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   fifo_empty_next;
  logic                   push;
  logic                   pop;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       hold_data_q, hold_data_d;
  logic [SEL_W-1:0]       hold_sel_q, hold_sel_d;
  logic                   ready_en_q;
  logic [LANES-1:0]       out_valid_q, out_valid_d;
  logic [LANES*WIDTH-1:0] out_data_q, out_data_d;
  logic                   busy_q, busy_d;

  logic                   sending;
  logic                   lane_rdy;
  logic                   deliver;
  logic                   drop;
  logic                   release_word;

  dispatch_fifo2 #(
    .W (FW)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .pop_i        (pop),
    .wdata_i      ({in_sel, in_data}),
    .rdata_o      (fifo_rdata),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full),
    .empty_next_o (fifo_empty_next)
  );

  // ready_en_q keeps in_ready low until the first edge after reset releases.
  assign in_ready     = ready_en_q & ~fifo_full;
  assign push         = in_valid & in_ready;
  assign sending      = (state_q == SEND);
  assign lane_rdy     = out_ready[hold_sel_q];
  assign deliver      = sending & lane_rdy;
  assign release_word = deliver | drop;
  assign pop          = ~fifo_empty & (~sending | release_word);

`ifdef DMUX8_DISPATCH_TIMEOUT_EN
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               err_q;

  // Drop fires on the stalled edge at which the counter would reach TIMEOUT.
  assign drop = sending & ~lane_rdy & (stall_q == STALL_W'(TIMEOUT - 1));

  always_comb begin
    stall_d = stall_q;
    if (pop | release_word) begin
      stall_d = '0;
    end else if (sending & ~lane_rdy) begin
      stall_d = stall_q + 8'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= drop;
    end
  end

  assign err_timeout = err_q;
`else
  assign drop        = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Holding register and FSM: load on pop, clear when the last word leaves.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_sel_d  = hold_sel_q;
    if (pop) begin
      state_d     = SEND;
      hold_data_d = fifo_rdata[WIDTH-1:0];
      hold_sel_d  = fifo_rdata[FW-1:WIDTH];
    end else if (release_word) begin
      state_d     = IDLE;
      hold_data_d = '0;
      hold_sel_d  = '0;
    end else begin
      state_d     = state_q;
    end
  end

  always_comb begin
    out_valid_d = '0;
    out_data_d  = '0;
    if (state_d == SEND) begin
      out_valid_d = lane_onehot(hold_sel_d);
    end else begin
      out_valid_d = '0;
    end
    for (int k = 0; k < LANES; k++) begin
      out_data_d[k*WIDTH +: WIDTH] = out_valid_d[k] ? hold_data_d : {WIDTH{1'b0}};
    end
    busy_d = ~fifo_empty_next | (state_d == SEND);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_data_q <= '0;
      hold_sel_q  <= '0;
      ready_en_q  <= 1'b0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_sel_q  <= hold_sel_d;
      ready_en_q  <= 1'b1;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dmux8_dispatch.sv
// Self-checking bench for dmux8_dispatch: directed table, corner sequences, random vs queue model.
module tb_dmux8_dispatch;

  localparam int W  = 16;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_data;
  logic [2:0]   in_sel;
  logic [127:0] out_data;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic         busy;
  logic         err_timeout;

  dmux8_dispatch #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level reference: a word queue of depth 2 plus one held slot.
  logic [18:0] mq[$];
  bit          m_held;
  logic [15:0] m_hd;
  logic [2:0]  m_hs;
  int          m_stall;
  bit          m_ren;
  bit          m_err;

  logic [18:0] obs_q[$];
  int          obs_cyc[$];
  int          cyc;
  int          n_err_seen;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [2:0]  s;
    logic [7:0]  r;
    logic        e_ir;
    logic [7:0]  e_ov;
    logic [15:0] e_d;
    logic        e_busy;
    logic        e_err;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] lane_bus(input logic [7:0] ov, input logic [15:0] d);
    logic [127:0] b;
    b = '0;
    for (int k = 0; k < 8; k++) begin
      if (ov == (8'd1 << k)) b = {112'd0, d} << (16 * k);
    end
    return b;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_held  = 0;
    m_hd    = '0;
    m_hs    = '0;
    m_stall = 0;
    m_ren   = 0;
    m_err   = 0;
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic [2:0] s, input logic [7:0] r);
    bit ir, acc, rel;
    logic [18:0] head;
    logic [7:0]  e_ov;
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    out_ready = r;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (out_valid[k] && r[k]) begin
        obs_q.push_back({3'(k), out_data[k*16 +: 16]});
        obs_cyc.push_back(cyc);
      end
    end
    ir    = m_ren && (mq.size() < 2);
    acc   = v && ir;
    m_err = 0;
    rel   = 0;
    if (m_held) begin
      if (r[m_hs]) begin
        rel = 1;
      end else begin
        m_stall++;
`ifdef DMUX8_DISPATCH_TIMEOUT_EN
        if (m_stall == TO) begin
          rel   = 1;
          m_err = 1;
        end
`endif
      end
      if (rel) m_held = 0;
    end
    if (!m_held && mq.size() > 0) begin
      head    = mq.pop_front();
      m_hs    = head[18:16];
      m_hd    = head[15:0];
      m_held  = 1;
      m_stall = 0;
    end
    if (acc) mq.push_back({s, d});
    m_ren = 1;
    e_ov  = m_held ? (8'd1 << m_hs) : 8'd0;
    @(posedge clk);
    #1;
    cyc++;
    check("in_ready", in_ready, m_ren && (mq.size() < 2));
    check("out_valid", out_valid, e_ov);
    check("out_data", out_data, lane_bus(e_ov, m_hd));
    check("busy", busy, m_held || (mq.size() > 0));
    check("err_timeout", err_timeout, m_err);
    if (err_timeout) n_err_seen++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".in_ready"}, in_ready, 1'b0);
    check({tag, ".out_valid"}, out_valid, 8'h00);
    check({tag, ".out_data"}, out_data, 128'd0);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".err_timeout"}, err_timeout, 1'b0);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_sel    = 3'd0;
    out_ready = 8'h00;
    reset     = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset.in_ready", in_ready, 1'b1);
    m_ren = 1;
    obs_q.delete();
    obs_cyc.delete();
    n_err_seen = 0;
  endtask

  initial begin
    logic [15:0] rd;
    logic [7:0]  rr;
    bit          ir_low;
    cyc       = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_sel    = 3'd0;
    out_ready = 8'h00;

    // Directed vectors: single word to lane 3, then back-pressure with three words.
    tbl[0] = '{1'b1, 16'hA5A5, 3'd3, 8'hFF, 1'b1, 8'h00, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 16'h0000, 3'd0, 8'hFF, 1'b1, 8'h08, 16'hA5A5, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 16'h0000, 3'd0, 8'hFF, 1'b1, 8'h00, 16'h0000, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 16'h1111, 3'd1, 8'h00, 1'b1, 8'h00, 16'h0000, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 16'h2222, 3'd2, 8'h00, 1'b1, 8'h02, 16'h1111, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 16'h3333, 3'd6, 8'hFD, 1'b0, 8'h02, 16'h1111, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 16'h4444, 3'd0, 8'hFD, 1'b0, 8'h02, 16'h1111, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 16'h0000, 3'd0, 8'hFF, 1'b1, 8'h04, 16'h2222, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 16'h0000, 3'd0, 8'hFF, 1'b1, 8'h40, 16'h3333, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 16'h0000, 3'd0, 8'hFF, 1'b1, 8'h00, 16'h0000, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_valid  = tbl[i].v;
      in_data   = tbl[i].d;
      in_sel    = tbl[i].s;
      out_ready = tbl[i].r;
      @(posedge clk);
      #1;
      check($sformatf("tbl[%0d].in_ready", i), in_ready, tbl[i].e_ir);
      check($sformatf("tbl[%0d].out_valid", i), out_valid, tbl[i].e_ov);
      check($sformatf("tbl[%0d].out_data", i), out_data, lane_bus(tbl[i].e_ov, tbl[i].e_d));
      check($sformatf("tbl[%0d].busy", i), busy, tbl[i].e_busy);
      check($sformatf("tbl[%0d].err", i), err_timeout, tbl[i].e_err);
    end

    // Streaming: eight words, one per cycle, every lane ready.
    do_reset();
    ir_low = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 16'h1000 + 16'(i), 3'(i), 8'hFF);
      if (!in_ready) ir_low = 1;
    end
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 3'd0, 8'hFF);
    check("stream.in_ready_dropped", ir_low, 1'b0);
    check("stream.count", obs_q.size(), 8);
    for (int i = 0; i < obs_q.size() && i < 8; i++) begin
      check($sformatf("stream.word%0d", i), obs_q[i], {3'(i), 16'h1000 + 16'(i)});
      check($sformatf("stream.cycle%0d", i), obs_cyc[i], obs_cyc[0] + i);
    end

    // Stall on lane 5 long enough to reach the timeout.
    do_reset();
    step(1'b1, 16'h5555, 3'd5, 8'h00);
    step(1'b1, 16'h6666, 3'd2, 8'hDF);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 3'd0, 8'hDF);
`ifdef DMUX8_DISPATCH_TIMEOUT_EN
    check("timeout.err_pulses", n_err_seen, 1);
    check("timeout.next_loaded", out_valid, 8'h04);
`else
    check("timeout.err_pulses", n_err_seen, 0);
    check("timeout.still_held", out_valid, 8'h20);
`endif
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 3'd0, 8'hFF);
    check("timeout.err_after", n_err_seen, (`ifdef DMUX8_DISPATCH_TIMEOUT_EN 1 `else 0 `endif));
`ifdef DMUX8_DISPATCH_TIMEOUT_EN
    check("timeout.deliveries", obs_q.size(), 1);
    if (obs_q.size() > 0) check("timeout.survivor", obs_q[0], {3'd2, 16'h6666});
`else
    check("timeout.deliveries", obs_q.size(), 2);
    if (obs_q.size() > 1) begin
      check("timeout.first", obs_q[0], {3'd5, 16'h5555});
      check("timeout.second", obs_q[1], {3'd2, 16'h6666});
    end
`endif

    // Reset while one word is held and two are queued.
    do_reset();
    step(1'b1, 16'hAAAA, 3'd4, 8'h00);
    step(1'b1, 16'hBBBB, 3'd5, 8'h00);
    step(1'b1, 16'hCCCC, 3'd6, 8'h00);
    check("midreset.full_before", in_ready, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midreset.in_ready_after", in_ready, 1'b1);
    m_ren = 1;
    obs_q.delete();
    obs_cyc.delete();
    n_err_seen = 0;
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 3'd0, 8'hFF);
    check("midreset.no_delivery", obs_q.size(), 0);
    check("midreset.no_err", n_err_seen, 0);

    // Randomized traffic against the queue model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rd = 16'($urandom);
      rr = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      step(($urandom_range(0, 3) != 0), rd, 3'($urandom_range(0, 7)), rr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
